// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a 16-entry note memory, holding each note for dur+1 beats
// followed by a one-beat gap, and drives the 7-segment note decoder inputs.
module melody_sequencer #(
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned SEQ_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    input  logic [3:0] last_step,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [6:0] wr_data,
    output logic       tom,
    output logic [2:0] notas,
    output logic       note_valid,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    beat_q, beat_d;
    logic [3:0]    step_q, step_d;
    logic [6:0]    mem_q [SEQ_LEN];
    logic [6:0]    mem_d [SEQ_LEN];
    logic [6:0]    cur;
    logic          tick;

    assign cur  = mem_q[step_q];
    assign tick = (presc_q == TickMax);

    // Notes may only be reprogrammed while stopped, so playback never sees a torn entry.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && state_q == StIdle) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        beat_d  = beat_q;
        step_d  = step_q;
        if (stop) begin
            state_d = StIdle;
            step_d  = '0;
            presc_d = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StPlay;
                        step_d  = '0;
                        presc_d = '0;
                        beat_d  = '0;
                    end
                end
                StPlay: begin
                    if (!pause) begin
                        if (tick) begin
                            presc_d = '0;
                            if (beat_q == cur[2:0]) begin
                                state_d = StGap;
                                beat_d  = '0;
                            end else begin
                                beat_d = beat_q + 3'd1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                StGap: begin
                    if (!pause) begin
                        if (tick) begin
                            presc_d = '0;
                            // last_step and loop are sampled here, so they may change mid-play.
                            if (step_q != last_step) begin
                                step_d  = step_q + 4'd1;
                                state_d = StPlay;
                            end else if (loop) begin
                                step_d  = '0;
                                state_d = StPlay;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            beat_q  <= '0;
            step_q  <= '0;
            for (int i = 0; i < SEQ_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            mem_q   <= mem_d;
        end
    end

    assign note_valid = (state_q == StPlay);
    assign tom        = note_valid ? cur[6] : 1'b0;
    assign notas      = note_valid ? cur[5:3] : 3'b000;
    assign step       = step_q;
    assign busy       = (state_q == StPlay) || (state_q == StGap);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares whenever the DUT is busy or pulsing done.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] last_step = 4'd0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [6:0] wr_data = 7'd0;
    logic       tom;
    logic [2:0] notas;
    logic       note_valid;
    logic [3:0] step;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       tom;
        logic [2:0] notas;
        logic       nv;
        logic [3:0] step;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_act;
    obs_t mon_exp;
    int   n_checks = 0;
    int   n_fail = 0;

    melody_sequencer #(.TICK_DIV(4), .SEQ_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop       (loop),
        .last_step  (last_step),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tom        (tom),
        .notas      (notas),
        .note_valid (note_valid),
        .step       (step),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && (busy || done)) begin
            mon_act = {tom, notas, note_valid, step, busy, done};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none at %0t", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cycle_out", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_play(input logic [3:0] s, input logic t, input logic [2:0] n,
                             input int cycles);
        obs_t o;
        o = {t, n, 1'b1, s, 1'b1, 1'b0};
        for (int i = 0; i < cycles; i++) exp_q.push_back(o);
    endtask

    task automatic push_note(input logic [3:0] s, input logic t, input logic [2:0] n,
                             input int dur, input int extra);
        obs_t o;
        push_play(s, t, n, (dur + 1) * 4 + extra);
        o = {1'b0, 3'b000, 1'b0, s, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) exp_q.push_back(o);
    endtask

    task automatic push_done(input logic [3:0] s);
        obs_t o;
        o = {1'b0, 3'b000, 1'b0, s, 1'b0, 1'b1};
        exp_q.push_back(o);
    endtask

    task automatic mem_write(input logic [3:0] a, input logic [6:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        tick(3);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_note_valid"}, 32'(note_valid), 32'd0);
        check({name, "_tom"}, 32'(tom), 32'd0);
        check({name, "_notas"}, 32'(notas), 32'd0);
        check({name, "_step"}, 32'(step), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_cleared("reset");
        #10 rst_n = 1'b1;
        tick(1);

        // Single note, dur=1: 8 play cycles, 4 gap cycles, one done.
        mem_write(4'd0, 7'b1_011_001);
        last_step = 4'd0;
        loop = 1'b0;
        push_note(4'd0, 1'b1, 3'b011, 1, 0);
        push_done(4'd0);
        do_start();
        drain("single");

        // Three steps, durs 0,2,1; pause 5 cycles during step 1 play.
        mem_write(4'd0, 7'b0_001_000);
        mem_write(4'd1, 7'b1_110_010);
        mem_write(4'd2, 7'b0_101_001);
        last_step = 4'd2;
        push_note(4'd0, 1'b0, 3'b001, 0, 0);
        push_note(4'd1, 1'b1, 3'b110, 2, 5);
        push_note(4'd2, 1'b0, 3'b101, 1, 0);
        push_done(4'd2);
        do_start();
        tick(10);
        pause = 1'b1;
        tick(5);
        pause = 1'b0;
        drain("three_step");

        // Loop over steps 0,1; loop cleared in the second step-1 gap.
        last_step = 4'd1;
        loop = 1'b1;
        push_note(4'd0, 1'b0, 3'b001, 0, 0);
        push_note(4'd1, 1'b1, 3'b110, 2, 0);
        push_note(4'd0, 1'b0, 3'b001, 0, 0);
        push_note(4'd1, 1'b1, 3'b110, 2, 0);
        push_done(4'd1);
        do_start();
        tick(45);
        loop = 1'b0;
        drain("loop");

        // stop with start held during step 1 play: IDLE next cycle, no done.
        last_step = 4'd2;
        push_note(4'd0, 1'b0, 3'b001, 0, 0);
        push_play(4'd1, 1'b1, 3'b110, 1);
        do_start();
        tick(8);
        stop = 1'b1;
        start = 1'b1;
        tick(1);
        check_cleared("stop");
        stop = 1'b0;
        start = 1'b0;
        drain("stop");

        // Write during PLAY is ignored; in IDLE (with start) it takes effect; dur=7 is 8 beats.
        mem_write(4'd0, 7'b1_100_000);
        last_step = 4'd0;
        push_note(4'd0, 1'b1, 3'b100, 0, 0);
        push_done(4'd0);
        do_start();
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 7'b0_111_111;
        tick(1);
        wr_en = 1'b0;
        drain("wr_gated");
        push_note(4'd0, 1'b0, 3'b111, 7, 0);
        push_done(4'd0);
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 7'b0_111_111;
        do_start();
        wr_en = 1'b0;
        drain("wr_idle");

        // Async reset mid-play clears outputs at once and empties the memory.
        push_note(4'd0, 1'b0, 3'b111, 7, 0);
        do_start();
        tick(2);
        #3 rst_n = 1'b0;
        #2 check_cleared("midreset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        push_note(4'd0, 1'b0, 3'b000, 0, 0);
        push_done(4'd0);
        do_start();
        drain("mem_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a stored melody on the xylophone note-display path.
- Steps through a small register-file of note entries, holding each note for a programmable number of beats with a one-beat gap between notes.
- Drives the tone/note inputs of the existing 7-segment note decoder, plus a display-enable.
- Sits between the user button/switch logic and the note decoder; it is the only source of that decoder's inputs.

Parameters:
- TICK_DIV, 12500000, clock cycles per beat (use 4 in simulation); minimum 2.
- SEQ_LEN, 16, number of note entries; fixed at 16 (4-bit addressing).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin playback from step 0 (level, sampled only in IDLE)
- stop  in  1  abort playback, return to IDLE
- pause  in  1  freeze timing while high (PLAY/GAP only)
- loop  in  1  1 = wrap to step 0 after last step
- last_step  in  4  index of final step played (0..15)
- wr_en  in  1  write strobe for note memory
- wr_addr  in  4  write address
- wr_data  in  7  {tom[6], notas[5:3], dur[2:0]}; note is held for dur+1 beats
- tom  out  1  tone bit to decoder
- notas  out  3  note code to decoder
- note_valid  out  1  display enable; high only in PLAY
- step  out  4  current step index
- busy  out  1  high in PLAY or GAP
- done  out  1  one-cycle pulse at end of non-looping playback

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - tom, notas, note_valid, step, busy and done all 0.
  - Prescaler and beat counter 0.
  - Note memory is cleared to 0.
- Memory:
  - 16 x 7-bit register array with combinational read at index step.
  - A write occurs on a clk edge when wr_en=1 and state=IDLE; it is ignored otherwise.
  - A write in the same cycle as an accepted start is performed. Step 0 then plays the new data, because the read happens the next cycle.
- States: IDLE, PLAY, GAP, DONE.
- IDLE:
  - With start=1 and stop=0: next state PLAY, step=0, prescaler=0, beat=0.
  - Otherwise IDLE.
- PLAY:
  - note_valid=1; tom/notas = mem[step] fields; busy=1.
  - Prescaler counts 0..TICK_DIV-1; its wrap is the beat tick.
  - The beat counter increments on each tick.
  - On the tick where beat==dur, go to GAP with prescaler and beat reset to 0.
  - PLAY lasts exactly (dur+1)*TICK_DIV cycles.
- GAP:
  - note_valid=0; tom=0, notas=0; busy=1.
  - Lasts exactly TICK_DIV cycles.
  - At the tick:
    - If step != last_step: step+1, go to PLAY.
    - Else if loop=1: step=0, go to PLAY.
    - Else go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0; step keeps last_step.
  - Next state IDLE.
- stop=1 in any state:
  - Next state IDLE; step, tom, notas and note_valid cleared.
  - No done pulse.
  - stop has priority over start, pause and ticks.
- pause=1 in PLAY/GAP: prescaler and beat counter hold, outputs hold, state holds. Ignored in IDLE/DONE.
- Sampling of last_step and loop:
  - last_step is sampled at each GAP tick, not latched at start.
  - loop is likewise sampled at the final GAP tick.
  - Both may change mid-playback.
- Boundaries:
  - last_step=0 plays a single note.
  - dur=7 gives 8 beats.
  - step wraps 15 -> 0 only via loop.
  - start held high through DONE restarts playback on the cycle after IDLE is re-entered.
- rst_n asserted mid-playback aborts immediately (async). The memory is cleared.

Test Plan:
- Reset: rst_n=0 mid-PLAY -> all outputs 0 immediately, state IDLE, mem reads 0.
- Single note (TICK_DIV=4):
  - Setup: mem[0]=7'b1_011_001, last_step=0, loop=0, start for 1 cycle.
  - note_valid=1, tom=1, notas=3'b011 for 8 cycles.
  - Then 4 gap cycles with note_valid=0.
  - Then done=1 for 1 cycle, busy=0.
- Three-step sequence with durs 0,2,1 -> PLAY lengths 4,12,8 cycles, each followed by a 4-cycle GAP; step goes 0,1,2; a single done pulse.
- Loop: last_step=1, loop=1 -> step sequence 0,1,0,1,...; no done.
  - Clear loop during the step-1 GAP -> done fires at the end of that GAP.
- Pause/stop:
  - pause for 5 cycles mid-PLAY -> that note lengthens by exactly 5 cycles.
  - stop with start both high -> IDLE next cycle, no done.
- Write gating:
  - wr_en during PLAY to the current step -> outputs unchanged.
  - The same write in IDLE is then read back on the next playback.
